// File: rtl/costas_loop_seq.sv
// Costas carrier-recovery sequencer: symbol-rate strobe, BPSK/QPSK select, loop-filter flush and lock detection.
// Optional acquisition timeout / re-seed is built when COSTAS_ACQ_TIMEOUT_EN is defined.
module costas_loop_seq #(
  parameter int              WIDTH        = 16,
  parameter int              DECIM        = 4,
  parameter int              WIN_LOG2     = 6,
  parameter int              FLUSH_LEN    = 8,
  parameter logic [WIDTH-1:0] LOCK_THR    = 16'd2048,
  parameter logic [WIDTH-1:0] UNLOCK_THR  = 16'd8192,
  parameter int              LOCK_WINS    = 3,
  parameter int              TIMEOUT_WINS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             mode_req,
  input  logic [WIDTH-1:0] err_tdata,
  input  logic             err_tvalid,
  output logic             ce_out,
  output logic             is_bpsk,
  output logic             loop_rst,
  output logic             gain_wide,
  output logic             locked,
  output logic [1:0]       state_out
`ifdef COSTAS_ACQ_TIMEOUT_EN
  ,
  output logic             acq_timeout
`endif
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FLUSH = 2'd1, S_ACQ = 2'd2, S_TRACK = 2'd3} state_t;

  localparam int ACC_W  = WIDTH + WIN_LOG2;
  localparam int DIV_W  = $clog2(DECIM);
  localparam int FL_W   = $clog2(FLUSH_LEN + 1);
  localparam int CONS_W = $clog2(LOCK_WINS + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};

  if (DECIM < 2 || TIMEOUT_WINS < 1) begin : g_bad_params
    $error("costas_loop_seq: DECIM must be >= 2 and TIMEOUT_WINS >= 1");
  end

  state_t               state_q, state_d;
  logic                 is_bpsk_q, is_bpsk_d;
  logic                 ce_q, loop_rst_q, gain_wide_q, locked_q, ce_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [FL_W-1:0]      flush_q, flush_d;
  logic [CONS_W-1:0]    cons_q, cons_d;
  logic [ACC_W-1:0]     acc_q, acc_d, win_sum;
  logic [WIN_LOG2-1:0]  samp_q, samp_d;
  logic [WIDTH-1:0]     abs_err, win_mean;
  logic                 run_q, run_d, win_done, win_good, win_bad;

`ifdef COSTAS_ACQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_WINS + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_fire, acq_timeout_q;
  assign acq_timeout = acq_timeout_q;
`endif

  // |x| with the most-negative code clamped so it stays representable.
  always_comb begin
    if (!err_tdata[WIDTH-1])       abs_err = err_tdata;
    else if (err_tdata == MOST_NEG) abs_err = MAX_POS;
    else                            abs_err = -err_tdata;
  end

  assign run_q    = (state_q == S_ACQ) || (state_q == S_TRACK);
  assign run_d    = (state_d == S_ACQ) || (state_d == S_TRACK);
  assign win_sum  = acc_q + ACC_W'(abs_err);
  assign win_mean = win_sum[ACC_W-1:WIN_LOG2];
  assign win_done = run_q && err_tvalid && (samp_q == '1);
  assign win_good = win_mean < LOCK_THR;
  assign win_bad  = win_mean > UNLOCK_THR;

  always_comb begin
    state_d   = state_q;
    is_bpsk_d = is_bpsk_q;
    cons_d    = cons_q;
`ifdef COSTAS_ACQ_TIMEOUT_EN
    tmo_fire  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_FLUSH;
          is_bpsk_d = mode_req;
        end
      end
      S_FLUSH: begin
        if (flush_q == FL_W'(FLUSH_LEN - 1)) state_d = S_ACQ;
      end
      S_ACQ: begin
        if (mode_req != is_bpsk_q) begin
          state_d   = S_FLUSH;
          is_bpsk_d = mode_req;
        end else if (win_done) begin
          if (!win_good)                             cons_d  = '0;
          else if (cons_q == CONS_W'(LOCK_WINS - 1)) state_d = S_TRACK;
          else                                       cons_d  = cons_q + CONS_W'(1);
`ifdef COSTAS_ACQ_TIMEOUT_EN
          if (state_d == S_ACQ && tmo_q == TMO_W'(TIMEOUT_WINS - 1)) begin
            state_d  = S_FLUSH;
            tmo_fire = 1'b1;
          end
`endif
        end
      end
      S_TRACK: begin
        if (mode_req != is_bpsk_q) begin
          state_d   = S_FLUSH;
          is_bpsk_d = mode_req;
        end else if (win_done) begin
          if (!win_bad)                              cons_d  = '0;
          else if (cons_q == CONS_W'(LOCK_WINS - 1)) state_d = S_ACQ;
          else                                       cons_d  = cons_q + CONS_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // stop outranks everything, including a mode change on the same cycle.
    if (stop) begin
      state_d   = S_IDLE;
      is_bpsk_d = is_bpsk_q;
`ifdef COSTAS_ACQ_TIMEOUT_EN
      tmo_fire  = 1'b0;
`endif
    end
    if (state_d != state_q) cons_d = '0;
  end

  // Divider and window accumulator only run while staying inside ACQ/TRACK.
  always_comb begin
    flush_d = (state_q == S_FLUSH && state_d == S_FLUSH) ? flush_q + FL_W'(1) : '0;
    ce_d    = run_q && run_d && (div_q == DIV_W'(DECIM - 1));
    div_d   = '0;
    acc_d   = '0;
    samp_d  = '0;
    if (run_q && run_d) begin
      div_d  = (div_q == DIV_W'(DECIM - 1)) ? '0 : div_q + DIV_W'(1);
      acc_d  = acc_q;
      samp_d = samp_q;
      if (err_tvalid) begin
        samp_d = samp_q + WIN_LOG2'(1);
        acc_d  = win_done ? '0 : win_sum;
      end
    end
`ifdef COSTAS_ACQ_TIMEOUT_EN
    tmo_d = (state_q == S_ACQ && state_d == S_ACQ) ? (win_done ? tmo_q + TMO_W'(1) : tmo_q) : '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      is_bpsk_q   <= 1'b1;
      ce_q        <= 1'b0;
      loop_rst_q  <= 1'b1;
      gain_wide_q <= 1'b1;
      locked_q    <= 1'b0;
      div_q       <= '0;
      flush_q     <= '0;
      cons_q      <= '0;
      acc_q       <= '0;
      samp_q      <= '0;
`ifdef COSTAS_ACQ_TIMEOUT_EN
      tmo_q         <= '0;
      acq_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      is_bpsk_q   <= is_bpsk_d;
      ce_q        <= ce_d;
      loop_rst_q  <= !run_d;
      gain_wide_q <= (state_d != S_TRACK);
      locked_q    <= (state_d == S_TRACK);
      div_q       <= div_d;
      flush_q     <= flush_d;
      cons_q      <= cons_d;
      acc_q       <= acc_d;
      samp_q      <= samp_d;
`ifdef COSTAS_ACQ_TIMEOUT_EN
      tmo_q         <= tmo_d;
      acq_timeout_q <= tmo_fire;
`endif
    end
  end

  assign ce_out    = ce_q;
  assign is_bpsk   = is_bpsk_q;
  assign loop_rst  = loop_rst_q;
  assign gain_wide = gain_wide_q;
  assign locked    = locked_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_costas_loop_seq.sv
// Bench for costas_loop_seq: directed flow with random error samples checked against a window-mean lock model.
module tb_costas_loop_seq;
  localparam int WIN        = 64;
  localparam int LOCK_THR   = 2048;
  localparam int UNLOCK_THR = 8192;
  localparam int LOCK_WINS  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        mode_req = 1'b0;
  logic [15:0] err_tdata = '0;
  logic        err_tvalid = 1'b0;
  logic        ce_out, is_bpsk, loop_rst, gain_wide, locked;
  logic [1:0]  state_out;
`ifdef COSTAS_ACQ_TIMEOUT_EN
  logic        acq_timeout;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  bit m_track;
  int m_cons;

  costas_loop_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode_req(mode_req),
    .err_tdata(err_tdata), .err_tvalid(err_tvalid),
    .ce_out(ce_out), .is_bpsk(is_bpsk), .loop_rst(loop_rst), .gain_wide(gain_wide),
    .locked(locked), .state_out(state_out)
`ifdef COSTAS_ACQ_TIMEOUT_EN
    , .acq_timeout(acq_timeout)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] s, input int max_cyc, input string tag);
    int n;
    n = 0;
    while (state_out !== s && n < max_cyc) begin
      tick();
      n++;
    end
    chk(tag, 32'(state_out), 32'(s));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state_out), 0);
    chk({tag, "_ce"}, 32'(ce_out), 0);
    chk({tag, "_bpsk"}, 32'(is_bpsk), 1);
    chk({tag, "_looprst"}, 32'(loop_rst), 1);
    chk({tag, "_gain"}, 32'(gain_wide), 1);
    chk({tag, "_locked"}, 32'(locked), 0);
  endtask

  // Drive one window of WIN valid samples with random idle gaps; returns the expected window mean.
  task automatic feed_window(input int lo, input int hi, input bit neg_only, input bit toggle_last,
                             output int mean);
    int sum, got, mag;
    bit neg;
    sum = 0;
    got = 0;
    while (got < WIN) begin
      if ($urandom_range(3, 0) == 0) begin
        err_tvalid = 1'b0;
        err_tdata  = 16'($urandom);
      end else begin
        mag = $urandom_range(hi, lo);
        neg = neg_only ? 1'b1 : 1'($urandom_range(1, 0));
        err_tvalid = 1'b1;
        err_tdata  = neg ? 16'(-mag) : 16'(mag);
        sum += (mag > 32767) ? 32767 : mag;
        got++;
        if (got == WIN && toggle_last) mode_req = ~mode_req;
      end
      tick();
    end
    err_tvalid = 1'b0;
    mean = sum / WIN;
  endtask

  task automatic model_window(input int mean);
    if (!m_track) begin
      if (mean < LOCK_THR) m_cons++;
      else m_cons = 0;
    end else begin
      if (mean > UNLOCK_THR) m_cons++;
      else m_cons = 0;
    end
    if (m_cons == LOCK_WINS) begin
      m_track = ~m_track;
      m_cons = 0;
    end
  endtask

  // G good, E mean exactly at lock threshold, U exactly at unlock threshold, B saturating bad, M between.
  task automatic run_pattern(input string pat, input string tag);
    int lo, hi, mean;
    bit neg;
    for (int i = 0; i < pat.len(); i++) begin
      neg = 1'b0;
      case (pat[i])
        "G": begin lo = 0;     hi = 1500;  end
        "E": begin lo = 2048;  hi = 2048;  end
        "U": begin lo = 8192;  hi = 8192;  end
        "B": begin lo = 32768; hi = 32768; neg = 1'b1; end
        default: begin lo = 4000; hi = 6000; end
      endcase
      feed_window(lo, hi, neg, 1'b0, mean);
      model_window(mean);
      chk($sformatf("%s_w%0d_state", tag, i), 32'(state_out), m_track ? 3 : 2);
      chk($sformatf("%s_w%0d_locked", tag, i), 32'(locked), 32'(m_track));
      chk($sformatf("%s_w%0d_gain", tag, i), 32'(gain_wide), 32'(!m_track));
    end
  endtask

  initial begin
    int n, mean;
    m_track = 1'b0;
    m_cons = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_hold", 32'(state_out), 0);

    // Start in QPSK; FLUSH must last exactly 8 cycles with loop_rst high.
    mode_req = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_state", 32'(state_out), 1);
    chk("start_bpsk", 32'(is_bpsk), 0);
    n = 0;
    while (state_out === 2'd1 && loop_rst === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("flush_len", n, 8);
    chk("acq_entry", 32'(state_out), 2);
    chk("acq_looprst", 32'(loop_rst), 0);
    chk("acq_gain", 32'(gain_wide), 1);

    for (int k = 4; k <= 20; k += 4) exp_q.push_back(32'(k));
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (ce_out === 1'b1) begin
        if (exp_q.size() > 0) chk("ce_time", k, exp_q.pop_front());
        else chk("ce_extra", 32'(ce_out), 0);
      end
    end
    chk("ce_count", exp_q.size(), 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ignored", 32'(state_out), 2);

    // Mode change in ACQ re-flushes; mode wiggles during FLUSH are ignored.
    mode_req = 1'b1;
    tick();
    chk("mode_flush_state", 32'(state_out), 1);
    chk("mode_flush_bpsk", 32'(is_bpsk), 1);
    chk("mode_flush_looprst", 32'(loop_rst), 1);
    tick();
    mode_req = 1'b0;
    tick();
    tick();
    mode_req = 1'b1;
    chk("flush_mode_ignored", 32'(is_bpsk), 1);
    wait_state(2'd2, 20, "reacq_entry");
    tick();
    tick();
    chk("reacq_stays", 32'(state_out), 2);

    m_track = 1'b0;
    m_cons = 0;
    run_pattern("GGEGGG", "lock");
    run_pattern("UBBB", "unlock");
    run_pattern("GGG", "relock");
    run_pattern("BBMBBMMMMM", "hold");

    // Mode toggle on the cycle the window completes: window discarded, FLUSH next cycle.
    feed_window(0, 1500, 1'b0, 1'b1, mean);
    chk("tog_state", 32'(state_out), 1);
    chk("tog_bpsk", 32'(is_bpsk), 0);
    chk("tog_locked", 32'(locked), 0);
    chk("tog_gain", 32'(gain_wide), 1);
    m_track = 1'b0;
    m_cons = 0;
    wait_state(2'd2, 20, "tog_reacq");
    run_pattern("GG", "tog_after");

    // stop and a mode change together in ACQ: stop wins, mode stays.
    stop = 1'b1;
    mode_req = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_state", 32'(state_out), 0);
    chk("stop_bpsk", 32'(is_bpsk), 0);
    chk("stop_ce", 32'(ce_out), 0);
    chk("stop_looprst", 32'(loop_rst), 1);
    chk("stop_locked", 32'(locked), 0);
    tick();
    tick();
    chk("stop_idle_hold", 32'(state_out), 0);

    // Asynchronous reset in the middle of FLUSH.
    mode_req = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_rst_state", 32'(state_out), 1);
    chk("pre_rst_bpsk", 32'(is_bpsk), 0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(state_out), 0);

`ifdef COSTAS_ACQ_TIMEOUT_EN
    mode_req = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("tmo_init", 32'(acq_timeout), 0);
    wait_state(2'd2, 20, "tmo_acq");
    for (int w = 0; w < 31; w++) begin
      feed_window(20000, 20000, 1'b0, 1'b0, mean);
      chk($sformatf("tmo_w%0d_state", w), 32'(state_out), 2);
      chk($sformatf("tmo_w%0d_pulse", w), 32'(acq_timeout), 0);
    end
    feed_window(20000, 20000, 1'b0, 1'b0, mean);
    chk("tmo_fire_state", 32'(state_out), 1);
    chk("tmo_fire_pulse", 32'(acq_timeout), 1);
    chk("tmo_fire_bpsk", 32'(is_bpsk), 0);
    tick();
    chk("tmo_pulse_width", 32'(acq_timeout), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
